// File: rtl/dcache_tag_ctrl_if.sv
// Lookup / fill / flush signal bundle for the data-cache tag controller.
interface dcache_tag_ctrl_if #(
    parameter int SET_ADDR_WIDTH = 9,
    parameter int TAG_WIDTH      = 21,
    parameter int WAYS           = 2
);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic                      req_valid;
    logic                      req_ready;
    logic [SET_ADDR_WIDTH-1:0] req_index;
    logic [TAG_WIDTH-1:0]      req_tag;
    logic                      rsp_valid;
    logic                      rsp_hit;
    logic [WAY_W-1:0]          rsp_way;
    logic                      fill_valid;
    logic                      fill_ready;
    logic [SET_ADDR_WIDTH-1:0] fill_index;
    logic [TAG_WIDTH-1:0]      fill_tag;
    logic                      fill_done;
    logic [WAY_W-1:0]          fill_way;
    logic                      flush_req;
    logic                      flush_busy;
    logic                      flush_done;

    modport master (
        output req_valid, req_index, req_tag, fill_valid, fill_index, fill_tag, flush_req,
        input  req_ready, rsp_valid, rsp_hit, rsp_way, fill_ready, fill_done, fill_way,
               flush_busy, flush_done
    );

    modport slave (
        input  req_valid, req_index, req_tag, fill_valid, fill_index, fill_tag, flush_req,
        output req_ready, rsp_valid, rsp_hit, rsp_way, fill_ready, fill_done, fill_way,
               flush_busy, flush_done
    );
endinterface

// File: rtl/dcache_tag_ctrl.sv
// Set-associative tag store with 1-cycle lookup, PLRU fill allocation and a
// one-set-per-cycle invalidate-all walk.
module dcache_tag_ctrl #(
    parameter int SET_ADDR_WIDTH = 9,
    parameter int TAG_WIDTH      = 21,
    parameter int WAYS           = 2
) (
    input logic               clk,
    input logic               rst_n,
    dcache_tag_ctrl_if.slave  bus
);
    localparam int SETS  = 1 << SET_ADDR_WIDTH;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PW    = (WAYS == 4) ? 3 : 1;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t                    state_q, state_d;
    logic [SET_ADDR_WIDTH-1:0] fcnt_q, fcnt_d;
    logic                      fdone_q, fdone_d;

    logic [TAG_WIDTH-1:0] tag_q   [SETS][WAYS];
    logic [WAYS-1:0]      valid_q [SETS];
    logic [PW-1:0]        plru_q  [SETS];

    logic             rsp_valid_q, rsp_hit_q, fill_done_q;
    logic [WAY_W-1:0] rsp_way_q, fill_way_q;

    logic             idle, req_acc, fill_acc, lk_hit;
    logic [1:0]       lk_way2, vict2;
    logic [WAY_W-1:0] lk_way, victim;

    // Victim named by the replacement bits (way number widened to 2 bits).
    function automatic logic [1:0] plru_victim(input logic [PW-1:0] p);
        logic [2:0] t;
        t = 3'(p);
        if (WAYS == 4)      return t[0] ? {1'b1, t[2]} : {1'b0, t[1]};
        else if (WAYS == 2) return {1'b0, t[0]};
        else                return 2'b00;
    endfunction

    // Point the bits on the accessed way's path away from it (mark MRU).
    function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] p, input logic [1:0] w);
        logic [2:0] t;
        t = 3'(p);
        if (WAYS == 4) begin
            t[0] = ~w[1];
            if (w[1]) t[2] = ~w[0];
            else      t[1] = ~w[0];
        end else if (WAYS == 2) begin
            t[0] = ~w[0];
        end else begin
            t = '0;
        end
        return PW'(t);
    endfunction

    assign idle     = (state_q == IDLE);
    assign req_acc  = bus.req_valid & idle;
    assign fill_acc = bus.fill_valid & idle;

    // Tag compare against current contents; descending scan leaves the lowest matching way.
    always_comb begin
        lk_hit  = 1'b0;
        lk_way2 = 2'b00;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[bus.req_index][w] && tag_q[bus.req_index][w] == bus.req_tag) begin
                lk_hit  = 1'b1;
                lk_way2 = 2'(w);
            end
        end
    end

    // Fill victim: lowest invalid way, falling back to the PLRU choice when the set is full.
    always_comb begin
        vict2 = plru_victim(plru_q[bus.fill_index]);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[bus.fill_index][w]) vict2 = 2'(w);
        end
    end

    assign lk_way = WAY_W'(lk_way2);
    assign victim = WAY_W'(vict2);

    // Flush FSM next state: the walk covers every set once, then returns to IDLE.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        fdone_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.flush_req) begin
                    state_d = FLUSH;
                    fcnt_d  = '0;
                end
            end
            FLUSH: begin
                fcnt_d = fcnt_q + 1'b1;
                if (&fcnt_q) begin
                    state_d = IDLE;
                    fdone_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, flush counter and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
            fdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            fdone_q <= fdone_d;
        end
    end

    // Valid and replacement state; the fill update is last so it wins on a shared set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else if (state_q == FLUSH) begin
            valid_q[fcnt_q] <= '0;
            plru_q[fcnt_q]  <= '0;
        end else begin
            if (req_acc && lk_hit)
                plru_q[bus.req_index] <= plru_touch(plru_q[bus.req_index], lk_way2);
            if (fill_acc) begin
                valid_q[bus.fill_index][victim] <= 1'b1;
                plru_q[bus.fill_index]          <= plru_touch(plru_q[bus.fill_index], vict2);
            end
        end
    end

    // Tag storage is never reset; valid bits qualify it.
    always_ff @(posedge clk) begin
        if (fill_acc) tag_q[bus.fill_index][victim] <= bus.fill_tag;
    end

    // Registered lookup result and fill acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_way_q   <= '0;
            fill_done_q <= 1'b0;
            fill_way_q  <= '0;
        end else begin
            rsp_valid_q <= req_acc;
            fill_done_q <= fill_acc;
            if (req_acc) begin
                rsp_hit_q <= lk_hit;
                rsp_way_q <= lk_way;
            end
            if (fill_acc) fill_way_q <= victim;
        end
    end

    assign bus.req_ready  = idle;
    assign bus.fill_ready = idle;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_hit    = rsp_hit_q;
    assign bus.rsp_way    = rsp_way_q;
    assign bus.fill_done  = fill_done_q;
    assign bus.fill_way   = fill_way_q;
    assign bus.flush_busy = (state_q == FLUSH);
    assign bus.flush_done = fdone_q;
endmodule
